// File: rtl/req_encoder_serial.sv
// Serial request encoder: captures an N-bit request vector, then emits the index of
// each set bit (lowest first), one beat per accepted output. Optional popcount port: ENC_POPCOUNT_EN.
module req_encoder_serial #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none,
    output logic         busy
`ifdef ENC_POPCOUNT_EN
    ,
    output logic [W:0]   out_cnt
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // A source holds its payload stable until the transfer; a sink may change ready freely.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state, state_next;
    logic [N-1:0] mask, mask_next;
    logic [N-1:0] mask_rest;
    logic [W-1:0] low_idx;
    logic         capture;
    logic         accept;

    // Clearing the lowest set bit is exactly the "remaining requests" after this beat.
    assign mask_rest = mask & (mask - N'(1));
    assign capture   = in_valid && in_ready;
    assign accept    = out_valid && out_ready;

    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) low_idx = W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mask  <= '0;
        end else begin
            state <= state_next;
            mask  <= mask_next;
        end
    end

    always_comb begin
        state_next = state;
        mask_next  = mask;
        case (state)
            IDLE: begin
                if (capture) begin
                    mask_next  = in_vec;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (accept) begin
                    mask_next = mask_rest;
                    if (out_last) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == EMIT);
        busy      = (state == EMIT);
        out_idx   = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        if (state == EMIT) begin
            out_idx  = low_idx;
            out_last = (mask_rest == '0);
            out_none = (mask == '0);
        end
    end

`ifdef ENC_POPCOUNT_EN
    logic [W:0] cap_cnt;

    always_comb begin
        cap_cnt = '0;
        for (int i = 0; i < N; i++) begin
            cap_cnt = cap_cnt + (W + 1)'(in_vec[i]);
        end
    end

    // Held for the whole vector; only a new capture may change it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (capture) begin
            out_cnt <= cap_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_req_encoder_serial.sv
// Bench for req_encoder_serial (N=4): directed cases plus random vectors, checked against a
// beat-list model built from the set bits of each captured vector.
module tb_req_encoder_serial;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int BW = 2 * W + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_vec = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_none;
    logic         busy;
`ifdef ENC_POPCOUNT_EN
    logic [W:0]   out_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;

    // Each expected beat packed as {cnt, none, last, idx}.
    logic [BW-1:0] exp_q[$];

    req_encoder_serial #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_last (out_last),
        .out_none (out_none),
        .busy     (busy)
`ifdef ENC_POPCOUNT_EN
        ,
        .out_cnt  (out_cnt)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: list the set bit positions in ascending order.
    task automatic push_expected(input logic [N-1:0] vec);
        int pos[$];
        logic [W:0] cnt;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) pos.push_back(i);
        end
        cnt = (W + 1)'(pos.size());
        if (pos.size() == 0) begin
            exp_q.push_back({cnt, 1'b1, 1'b1, W'(0)});
        end else begin
            for (int k = 0; k < pos.size(); k++) begin
                exp_q.push_back({cnt, 1'b0, (k == pos.size() - 1), W'(pos[k])});
            end
        end
    endtask

    // Output consumer pacing: 0 = always ready, 1 = random, 2 = toggle.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ~out_ready;
        endcase
    end

    // Scoreboard: the head of exp_q is what must be on the outputs right now.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                check("out_idx", 32'(out_idx), 32'(exp_q[0][W-1:0]));
                check("out_last", 32'(out_last), 32'(exp_q[0][W]));
                check("out_none", 32'(out_none), 32'(exp_q[0][W+1]));
`ifdef ENC_POPCOUNT_EN
                check("out_cnt", 32'(out_cnt), 32'(exp_q[0][BW-1:W+2]));
`endif
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Driver: present vec until the DUT takes it, then record its expected beats.
    task automatic send_vec(input logic [N-1:0] vec);
        bit taken = 0;
        in_valid = 1'b1;
        in_vec   = vec;
        for (int c = 0; c < 200 && !taken; c++) begin
            @(negedge clk);
            taken = in_ready && !rst;
            @(posedge clk);
            #1;
        end
        if (!taken) check("capture_timeout", 32'd0, 32'd1);
        else push_expected(vec);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            #1;
            done = (exp_q.size() == 0) && in_ready;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_out_none"}, 32'(out_none), 32'd0);
`ifdef ENC_POPCOUNT_EN
        check({tag, "_out_cnt"}, 32'(out_cnt), 32'd0);
`endif
    endtask

    initial begin
        // Power-on reset
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: two beats, idx 1 then 3
        ready_mode = 0;
        send_vec(4'b1010);
        wait_idle();

        // 2: all-zero vector gives one "none" beat
        send_vec(4'b0000);
        wait_idle();

        // 3: all-ones with a toggling consumer
        ready_mode = 2;
        send_vec(4'b1111);
        wait_idle();

        // 4: second vector held during EMIT is taken only afterwards
        ready_mode = 0;
        send_vec(4'b0110);
        send_vec(4'b0001);
        wait_idle();

        // 5: reset after the first beat of 4'b1100 drops everything
        send_vec(4'b1100);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // 6: back-to-back singles with in_valid held
        send_vec(4'b1000);
        send_vec(4'b0100);
        wait_idle();

        // Random vectors, random consumer pacing and input gaps
        for (int t = 0; t < 60; t++) begin
            ready_mode = $urandom_range(0, 2);
            send_vec(N'($urandom_range(0, (1 << N) - 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
